// File: rtl/demux1_to_4_tdm.sv
// 1-to-4 demultiplexer with explicit or TDM slot selection.
// Each output channel is a one-entry buffer with valid/ready handshake.
// A saturating stall counter raises a sticky overrun flag when the input
// waits on a full channel for 16 consecutive cycles.
module demux1_to_4_tdm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             mode,
    input  logic             s1,
    input  logic             s0,
    input  logic             sync,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       slot,
    output logic             overrun
);

    localparam logic [4:0] StallMax = 5'd31;
    localparam logic [4:0] StallLim = 5'd16;

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [1:0]       slot_q, slot_d;
    logic [4:0]       stall_q, stall_d;
    logic             overrun_q, overrun_d;

    logic [1:0]       tgt;
    logic             sync_qual;
    logic             accept;
    logic [3:0]       deliver;

    // Channel selection, handshake and acceptance.
    always_comb begin
        // sync only counts on a word that is actually present
        sync_qual = sync & in_valid;
        if (mode) begin
            tgt = sync_qual ? 2'd0 : slot_q;
        end else begin
            tgt = {s1, s0};
        end
        in_ready = ~valid_q[tgt] | out_ready[tgt];
        accept   = in_valid & in_ready;
        deliver  = valid_q & out_ready;
    end

    // Next state of channel buffers, slot counter, stall counter and overrun.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            data_d[k]  = data_q[k];
            valid_d[k] = valid_q[k] & ~deliver[k];
            // A load on the delivery edge keeps the channel full with the new word
            if (accept && (tgt == 2'(k))) begin
                data_d[k]  = in_data;
                valid_d[k] = 1'b1;
            end
        end

        slot_d = slot_q;
        if (mode && accept) begin
            slot_d = tgt + 2'd1;
        end

        stall_d = stall_q;
        if (!in_valid || accept) begin
            stall_d = 5'd0;
        end else if (stall_q != StallMax) begin
            stall_d = stall_q + 5'd1;
        end

        overrun_d = overrun_q | (stall_d == StallLim);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
            valid_q   <= 4'b0000;
            slot_q    <= 2'd0;
            stall_q   <= 5'd0;
            overrun_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q   <= valid_d;
            slot_q    <= slot_d;
            stall_q   <= stall_d;
            overrun_q <= overrun_d;
        end
    end

    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];
    assign out_valid = valid_q;
    assign slot      = slot_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux1_to_4_tdm.sv
// Scoreboard bench for demux1_to_4_tdm: accepted words are queued per channel
// and compared when the channel delivers them.
module tb_demux1_to_4_tdm;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       mode, s1, s0, sync, in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] out_valid, out_ready;
    logic [1:0] slot;
    logic       overrun;

    logic [7:0] outs [4];
    logic [7:0] exp_q [4][$];

    int n_checks = 0;
    int n_errors = 0;

    demux1_to_4_tdm #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode      (mode),
        .s1        (s1),
        .s0        (s0),
        .sync      (sync),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .overrun   (overrun)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Delivery monitor: a word leaves channel k at the coming edge.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("deliv_unexpected_ch%0d", k), 32'(outs[k]), 32'hxx);
                    end else begin
                        check($sformatf("deliv_ch%0d", k), 32'(outs[k]),
                              32'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        sync     = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one cycle of input, check in_ready, queue the word if accepted.
    task automatic drive(input logic v, input logic m, input logic [1:0] sel, input logic sy,
                         input logic [7:0] d, input logic exp_rdy, input logic [1:0] ch,
                         input string tag);
        in_valid = v;
        mode     = m;
        {s1, s0} = sel;
        sync     = sy;
        in_data  = d;
        @(negedge clock);
        check(tag, 32'(in_ready), 32'(exp_rdy));
        if (v && exp_rdy) exp_q[ch].push_back(d);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        sync     = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        mode      = 1'b0;
        {s1, s0}  = 2'd0;
        sync      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_slot", 32'(slot), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_outs", {out3, out2, out1, out0}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = 2'(k);
            #1;
            check("rst_in_ready", 32'(in_ready), 32'h1);
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Explicit select, one word per channel, all consumers ready.
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 2'(k), 1'b0, 8'hA0 + 8'(k), 1'b1, 2'(k), "t1_in_ready");
            check("t1_out_valid", 32'(out_valid), 32'(4'b0001 << k));
            check("t1_out_data", 32'(outs[k]), 32'(8'hA0 + 8'(k)));
        end
        idle(1);

        // TDM stream starting with sync.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 2'd0, (k == 0), 8'h10 + 8'(k), 1'b1, 2'(k % 4), "t2_in_ready");
            check("t2_slot", 32'(slot), 32'((k + 1) % 4));
        end
        idle(1);

        // Back-pressure on channel 2, then simultaneous deliver and load.
        out_ready = 4'h0;
        drive(1'b1, 1'b0, 2'd2, 1'b0, 8'h55, 1'b1, 2'd2, "t3_first");
        drive(1'b1, 1'b0, 2'd2, 1'b0, 8'h66, 1'b0, 2'd2, "t3_blocked");
        check("t3_out2_held", 32'(out2), 32'h55);
        out_ready = 4'b0100;
        drive(1'b1, 1'b0, 2'd2, 1'b0, 8'h66, 1'b1, 2'd2, "t3_accept");
        check("t3_valid2", 32'(out_valid[2]), 32'h1);
        check("t3_out2_new", 32'(out2), 32'h66);
        idle(1);

        // sync overrides slot 2.
        out_ready = 4'hF;
        drive(1'b1, 1'b1, 2'd0, 1'b0, 8'h40, 1'b1, 2'd0, "t4_w0");
        drive(1'b1, 1'b1, 2'd0, 1'b0, 8'h41, 1'b1, 2'd1, "t4_w1");
        check("t4_slot2", 32'(slot), 32'h2);
        drive(1'b1, 1'b1, 2'd0, 1'b1, 8'h77, 1'b1, 2'd0, "t4_sync");
        check("t4_slot_after_sync", 32'(slot), 32'h1);
        idle(1);

        // Overrun after 16 stalled cycles on channel 3, then async reset.
        out_ready = 4'b0111;
        drive(1'b1, 1'b0, 2'd3, 1'b0, 8'h3C, 1'b1, 2'd3, "t5_load3");
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 2'd3, 1'b0, 8'hEE, 1'b0, 2'd3, "t5_stall");
            check($sformatf("t5_overrun_c%0d", i + 1), 32'(overrun), 32'(i == 15));
        end
        out_ready = 4'hF;
        idle(2);
        check("t5_overrun_sticky", 32'(overrun), 32'h1);
        check("t5_drained", 32'(out_valid), 32'h0);
        out_ready = 4'h0;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 8'h5A, 1'b1, 2'd0, "t5_load0");
        check("t5_valid0", 32'(out_valid), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_overrun", 32'(overrun), 32'h0);
        check("t5_rst_valid", 32'(out_valid), 32'h0);
        check("t5_rst_out0", 32'(out0), 32'h0);
        exp_q[0].delete();
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("t5_post_rst_valid", 32'(out_valid), 32'h0);
        @(posedge clock);
        #1;

        // Channel 1 stalled while channels 0 and 3 stream.
        out_ready = 4'b1001;
        drive(1'b1, 1'b0, 2'd1, 1'b0, 8'h31, 1'b1, 2'd1, "t6_load1");
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, (i % 2 == 0) ? 2'd0 : 2'd3, 1'b0, 8'h80 + 8'(i), 1'b1,
                  (i % 2 == 0) ? 2'd0 : 2'd3, "t6_in_ready");
            check("t6_nogap", 32'(out_valid[(i % 2 == 0) ? 0 : 3]), 32'h1);
        end
        check("t6_out1_held", 32'(out1), 32'h31);
        check("t6_valid1", 32'(out_valid[1]), 32'h1);
        out_ready = 4'hF;
        idle(3);

        for (int k = 0; k < 4; k++) begin
            check($sformatf("end_queue_ch%0d", k), 32'(exp_q[k].size()), 32'h0);
        end
        check("end_valid", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
